// File: rtl/softmax_pkg.sv
// Shared types and default sizing for the softmax engine.
package softmax_pkg;

    localparam int N_CLASSES_DEF = 10;
    localparam int DATA_W_DEF    = 16;
    localparam int FRAC_W_DEF    = DATA_W_DEF - 1;

    typedef enum logic [2:0] {
        IDLE,
        MAX,
        EXP,
        SUM,
        DIV,
        HOLD
    } state_t;

endpackage

// File: rtl/softmax_div.sv
// Sequential restoring divider: one quotient bit per cycle, QUOT_W cycles per division.
module softmax_div #(
    parameter int DIVIDEND_W = 31,
    parameter int DIVISOR_W  = 20,
    parameter int QUOT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [QUOT_W-1:0]     quotient
);

    localparam int CNT_W = $clog2(QUOT_W + 1);

    logic [DIVISOR_W-1:0] rem, dsr, src_rem, src_dsr, diff, next_rem;
    logic [QUOT_W-1:0]    shreg, src_sh, next_sh;
    logic [DIVISOR_W:0]   trial;
    logic [CNT_W-1:0]     count;
    logic                 load, ge;

    // The load cycle already performs the first iteration on the fresh operands.
    always_comb begin
        load     = start && !busy;
        src_rem  = load ? DIVISOR_W'(dividend[DIVIDEND_W-1:QUOT_W]) : rem;
        src_sh   = load ? dividend[QUOT_W-1:0] : shreg;
        src_dsr  = load ? divisor : dsr;
        trial    = {src_rem, src_sh[QUOT_W-1]};
        ge       = trial >= {1'b0, src_dsr};
        diff     = trial[DIVISOR_W-1:0] - src_dsr;
        next_rem = ge ? diff : trial[DIVISOR_W-1:0];
        next_sh  = {src_sh[QUOT_W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
            rem   <= '0;
            shreg <= '0;
            dsr   <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                rem   <= next_rem;
                shreg <= next_sh;
                dsr   <= divisor;
                count <= CNT_W'(QUOT_W - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                rem   <= next_rem;
                shreg <= next_sh;
                count <= count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = shreg;

endmodule

// File: rtl/softmax_engine.sv
// Multi-cycle softmax: max search, quadratic exp approximation, sum, per-element divide.
// Optional argmax output enabled by defining SOFTMAX_ARGMAX_EN.
module softmax_engine
    import softmax_pkg::*;
#(
    parameter int N_CLASSES = N_CLASSES_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAC_W    = DATA_W - 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CLASSES*DATA_W-1:0]   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [N_CLASSES*DATA_W-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready
`ifdef SOFTMAX_ARGMAX_EN
    ,
    output logic [$clog2(N_CLASSES)-1:0]  argmax
`endif
);

    localparam int IDX_W  = $clog2(N_CLASSES);
    localparam int SUM_W  = DATA_W + $clog2(N_CLASSES);
    localparam int XW     = DATA_W + 1;
    localparam int SQ_W   = 2 * XW;
    localparam int DIVN_W = DATA_W + FRAC_W;
    localparam logic [XW-1:0]     X_LIM    = XW'(1) << FRAC_W;
    localparam logic [DATA_W-1:0] E_MAX    = DATA_W'(X_LIM - XW'(1));
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t state, next_state;

    // Holds the captured logits, then is overwritten in place by the exp terms.
    logic        [DATA_W-1:0] data_mem [N_CLASSES];
    logic        [IDX_W-1:0]  idx, div_sel;
    logic signed [DATA_W-1:0] max_val, cur;
    logic        [SUM_W-1:0]  sum;
    logic        [XW-1:0]     ax;
    logic        [SQ_W-1:0]   sq, e_pos, e_lin;
    logic        [DATA_W-1:0] e_val, div_q, q_sat;
    logic        [DIVN_W-1:0] div_dividend;
    logic                     idx_last, div_start, div_busy, div_done;

    assign idx_last = (idx == IDX_W'(N_CLASSES - 1));
    assign cur      = data_mem[idx];

    // Works on |x| = max - logit so the polynomial stays in unsigned arithmetic.
    always_comb begin
        ax    = {max_val[DATA_W-1], max_val} - {cur[DATA_W-1], cur};
        sq    = SQ_W'(ax) * SQ_W'(ax);
        e_pos = SQ_W'(E_MAX) + (sq >> (FRAC_W + 1));
        e_lin = e_pos - SQ_W'(ax);
        e_val = '0;
        if (ax <= X_LIM && e_pos >= SQ_W'(ax)) begin
            e_val = (e_lin > SQ_W'(E_MAX)) ? E_MAX : e_lin[DATA_W-1:0];
        end
    end

    assign div_sel      = (div_done && !idx_last) ? idx + IDX_W'(1) : idx;
    assign div_dividend = DIVN_W'(data_mem[div_sel]) << FRAC_W;
    assign q_sat        = (div_q > E_MAX) ? E_MAX : div_q;

    softmax_div #(
        .DIVIDEND_W(DIVN_W),
        .DIVISOR_W (SUM_W),
        .QUOT_W    (DATA_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (div_start),
        .dividend(div_dividend),
        .divisor (sum),
        .busy    (div_busy),
        .done    (div_done),
        .quotient(div_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        div_start  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = MAX;
            end
            MAX:  if (idx_last) next_state = EXP;
            EXP:  if (idx_last) next_state = SUM;
            SUM:  if (idx_last) next_state = DIV;
            DIV: begin
                if (div_done && idx_last) next_state = HOLD;
                else if (!div_busy)       div_start  = 1'b1;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            max_val  <= '0;
            sum      <= '0;
            out_data <= '0;
            for (int unsigned i = 0; i < N_CLASSES; i++) data_mem[i] <= '0;
`ifdef SOFTMAX_ARGMAX_EN
            argmax   <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    for (int unsigned i = 0; i < N_CLASSES; i++)
                        data_mem[i] <= in_data[i*DATA_W +: DATA_W];
                    idx     <= '0;
                    max_val <= MOST_NEG;
                    sum     <= '0;
`ifdef SOFTMAX_ARGMAX_EN
                    argmax  <= '0;
`endif
                end
                MAX: begin
                    if (cur > max_val) begin
                        max_val <= cur;
`ifdef SOFTMAX_ARGMAX_EN
                        argmax  <= idx;
`endif
                    end
                    idx <= idx_last ? '0 : idx + IDX_W'(1);
                end
                EXP: begin
                    data_mem[idx] <= e_val;
                    idx <= idx_last ? '0 : idx + IDX_W'(1);
                end
                SUM: begin
                    sum <= sum + SUM_W'(cur);
                    idx <= idx_last ? '0 : idx + IDX_W'(1);
                end
                DIV: if (div_done) begin
                    out_data[idx*DATA_W +: DATA_W] <= q_sat;
                    idx <= idx_last ? '0 : idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_engine.sv
// Self-checking bench for softmax_engine: directed spec vectors plus randomized vectors vs a reference model.
module tb_softmax_engine;

    localparam int N   = softmax_pkg::N_CLASSES_DEF;
    localparam int DW  = softmax_pkg::DATA_W_DEF;
    localparam int FW  = softmax_pkg::FRAC_W_DEF;
    localparam int LAT = 3*N + N*DW + 1;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready;
    logic [N*DW-1:0] in_data, out_data;
`ifdef SOFTMAX_ARGMAX_EN
    logic [$clog2(N)-1:0] argmax;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    softmax_engine #(
        .N_CLASSES(N),
        .DATA_W   (DW),
        .FRAC_W   (FW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef SOFTMAX_ARGMAX_EN
        ,
        .argmax   (argmax)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] val);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = val;
        return r;
    endfunction

    function automatic logic [N*DW-1:0] rand_vec(input int mode);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) begin
            if (mode == 0)      r[i*DW +: DW] = DW'($urandom);
            else if (mode == 1) r[i*DW +: DW] = DW'(int'($urandom_range(6000)) - 3000);
            else                r[i*DW +: DW] = DW'(int'($urandom_range(40000)) - 20000);
        end
        return r;
    endfunction

    // Reference softmax straight from the arithmetic definition, in 64-bit integers.
    function automatic void model(input logic [N*DW-1:0] vec, output logic [N*DW-1:0] q_out,
                                  output int arg);
        longint v[N];
        longint e[N];
        longint mx, sum, x, q, one;
        logic signed [DW-1:0] s;
        one = longint'(1) << FW;
        for (int i = 0; i < N; i++) begin
            s = vec[i*DW +: DW];
            v[i] = s;
        end
        mx = v[0];
        arg = 0;
        for (int i = 1; i < N; i++) if (v[i] > mx) begin mx = v[i]; arg = i; end
        sum = 0;
        for (int i = 0; i < N; i++) begin
            x = v[i] - mx;
            if (x >= -one) e[i] = (one - 1) + x + (x * x) / (2 * one);
            else           e[i] = 0;
            if (e[i] < 0)       e[i] = 0;
            if (e[i] > one - 1) e[i] = one - 1;
            sum += e[i];
        end
        q_out = '0;
        for (int i = 0; i < N; i++) begin
            q = (e[i] * one) / sum;
            if (q > one - 1) q = one - 1;
            q_out[i*DW +: DW] = DW'(q);
        end
    endfunction

    task automatic start_vec(input string tag, input logic [N*DW-1:0] vec);
        in_data  = vec;
        in_valid = 1'b1;
        check($sformatf("%s_in_ready", tag), 256'(in_ready), 256'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_check(input string tag, input logic [N*DW-1:0] expq, input int exparg);
        int cnt = 0;
        while (out_valid !== 1'b1 && cnt < 2*LAT) begin
            in_data = rand_vec(0);
            tick();
            cnt++;
        end
        check($sformatf("%s_latency", tag), 256'(cnt), 256'(LAT));
        check($sformatf("%s_data", tag), 256'(out_data), 256'(expq));
`ifdef SOFTMAX_ARGMAX_EN
        check($sformatf("%s_argmax", tag), 256'(argmax), 256'(exparg));
`else
        if (exparg < 0) $display("unexpected negative argmax in %s", tag);
`endif
    endtask

    task automatic release_hold(input string tag, input logic [N*DW-1:0] expq);
        repeat (2) tick();
        check($sformatf("%s_hold_valid", tag), 256'(out_valid), 256'(1));
        check($sformatf("%s_hold_data", tag), 256'(out_data), 256'(expq));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check($sformatf("%s_post_valid", tag), 256'(out_valid), 256'(0));
        check($sformatf("%s_post_ready", tag), 256'(in_ready), 256'(1));
    endtask

    task automatic run_vec(input string tag, input logic [N*DW-1:0] vec,
                           input logic [N*DW-1:0] expq, input int exparg);
        start_vec(tag, vec);
        wait_check(tag, expq, exparg);
        release_hold(tag, expq);
    endtask

    initial begin
        logic [N*DW-1:0] v, e;
        int a, seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) tick();
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_data", 256'(out_data), 256'(0));
`ifdef SOFTMAX_ARGMAX_EN
        check("rst_argmax", 256'(argmax), 256'(0));
`endif
        rst = 1'b0;
        tick();

        run_vec("zero", '0, fill(16'h0CCC), 0);

        v = '0; v[3*DW +: DW] = 16'h4000;
        e = fill(16'h0C13); e[3*DW +: DW] = 16'h1352;
        run_vec("class3", v, e, 3);

        v = fill(16'h8000); v[0 +: DW] = 16'h7FFF;
        e = '0; e[0 +: DW] = 16'h7FFF;
        run_vec("saturate", v, e, 0);

        v = '0; v[2*DW +: DW] = 16'h1000; v[7*DW +: DW] = 16'h1000;
        e = fill(16'h0C78); e[2*DW +: DW] = 16'h0E1F; e[7*DW +: DW] = 16'h0E1F;
        run_vec("tie", v, e, 2);

        run_vec("all_min", fill(16'h8000), fill(16'h0CCC), 0);

        for (int k = 0; k < 9; k++) begin
            v = rand_vec(k % 3);
            model(v, e, a);
            run_vec($sformatf("rand%0d", k), v, e, a);
        end

        // Downstream stalls 20 cycles, then the next vector waits on the handshake.
        start_vec("stall", '0);
        wait_check("stall", fill(16'h0CCC), 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("stall_data", 256'(out_data), 256'(fill(16'h0CCC)));
            check("stall_in_ready", 256'(in_ready), 256'(0));
            check("stall_valid", 256'(out_valid), 256'(1));
        end
        v = '0; v[3*DW +: DW] = 16'h4000;
        e = fill(16'h0C13); e[3*DW +: DW] = 16'h1352;
        in_data = v; in_valid = 1'b1; out_ready = 1'b1;
        check("hs_in_ready", 256'(in_ready), 256'(0));
        tick();
        out_ready = 1'b0;
        check("after_hs_in_ready", 256'(in_ready), 256'(1));
        check("after_hs_valid", 256'(out_valid), 256'(0));
        tick();
        in_valid = 1'b0;
        wait_check("next_after_hs", e, 3);
        release_hold("next_after_hs", e);

        // Downstream already ready: result visible for exactly one cycle.
        v = rand_vec(1);
        model(v, e, a);
        out_ready = 1'b1;
        start_vec("early", v);
        wait_check("early", e, a);
        tick();
        check("early_one_cycle", 256'(out_valid), 256'(0));
        check("early_in_ready", 256'(in_ready), 256'(1));
        out_ready = 1'b0;

        // Reset in the middle of the divide phase drops the vector.
        start_vec("abort", rand_vec(2));
        repeat (100) tick();
        check("abort_pre_valid", 256'(out_valid), 256'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 256'(in_ready), 256'(1));
        check("abort_out_data", 256'(out_data), 256'(0));
`ifdef SOFTMAX_ARGMAX_EN
        check("abort_argmax", 256'(argmax), 256'(0));
`endif
        seen = 0;
        repeat (250) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        check("abort_no_valid", 256'(seen), 256'(0));
        run_vec("after_abort", '0, fill(16'h0CCC), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
